// File: rtl/mips_cpu_multdiv_ctrl.sv
// HI/LO owner and mult/div sequencer: multi-cycle multiply, 32-step restoring divide, MT/MF access.
// Optional MULTDIV_DIV0_FAST_EN: divide by zero finishes in one busy cycle and leaves HI/LO untouched.
module mips_cpu_multdiv_ctrl #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_DIVU  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_MULT  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MFHI  = 3'b110;
    localparam logic [2:0] OP_MFLO  = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DIV_ITER, DIV_FIX} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] rem;
    logic        is_signed;
    logic        neg_q;
    logic        neg_r;
`ifdef MULTDIV_DIV0_FAST_EN
    logic        div_zero;
`endif

    logic        div_signed;
    logic [31:0] rs_abs;
    logic [31:0] rt_abs;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic        mf_hit;

    assign div_signed = (op_code == OP_DIV);
    assign rs_abs     = (div_signed && rs_val[31]) ? 32'd0 - rs_val : rs_val;
    assign rt_abs     = (div_signed && rt_val[31]) ? 32'd0 - rt_val : rt_val;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign ext_a   = {{32{is_signed & opa[31]}}, opa};
    assign ext_b   = {{32{is_signed & opb[31]}}, opb};
    assign product = ext_a * ext_b;

    // opa doubles as the dividend/quotient shift register during division.
    assign shifted = {rem, opa[31]};
    assign ge      = (shifted >= {1'b0, opb});
    assign diff    = shifted[31:0] - opb;
    assign quo_fix = neg_q ? 32'd0 - opa : opa;
    assign rem_fix = neg_r ? 32'd0 - rem : rem;

    assign busy         = (state != IDLE);
    assign stall        = op_valid && busy;
    assign mf_hit       = (state == IDLE) && op_valid && (op_code == OP_MFHI || op_code == OP_MFLO);
    assign result_valid = mf_hit;
    assign result       = mf_hit ? ((op_code == OP_MFLO) ? lo : hi) : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            opa       <= 32'd0;
            opb       <= 32'd0;
            rem       <= 32'd0;
            is_signed <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
`ifdef MULTDIV_DIV0_FAST_EN
            div_zero  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            OP_MULT, OP_MULTU: begin
                                opa       <= rs_val;
                                opb       <= rt_val;
                                is_signed <= (op_code == OP_MULT);
                                cnt       <= 5'(MUL_CYCLES - 1);
                                state     <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                opa   <= rs_abs;
                                opb   <= rt_abs;
                                rem   <= 32'd0;
                                neg_q <= div_signed && (rs_val[31] ^ rt_val[31]);
                                neg_r <= div_signed && rs_val[31];
                                cnt   <= 5'd31;
`ifdef MULTDIV_DIV0_FAST_EN
                                div_zero <= (rt_val == 32'd0);
                                state    <= (rt_val == 32'd0) ? DIV_FIX : DIV_ITER;
`else
                                state    <= DIV_ITER;
`endif
                            end
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (cnt == 5'd0) begin
                        {hi, lo} <= product;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                DIV_ITER: begin
                    opa <= {opa[30:0], ge};
                    rem <= ge ? diff : shifted[31:0];
                    if (cnt == 5'd0)
                        state <= DIV_FIX;
                    else
                        cnt <= cnt - 5'd1;
                end
                DIV_FIX: begin
`ifdef MULTDIV_DIV0_FAST_EN
                    if (!div_zero) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
`else
                    hi <= rem_fix;
                    lo <= quo_fix;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_multdiv_ctrl.sv
// Directed bench for mips_cpu_multdiv_ctrl: vector table plus hand-written stall/reset sequences.
module tb_mips_cpu_multdiv_ctrl;

    localparam logic [2:0] OP_DIVU  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_MULT  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MFHI  = 3'b110;
    localparam logic [2:0] OP_MFLO  = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic [31:0] result;
    logic        result_valid;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int assertions = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[14];

    mips_cpu_multdiv_ctrl #(.MUL_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .op_valid(op_valid),
        .op_code(op_code),
        .rs_val(rs_val),
        .rt_val(rt_val),
        .result(result),
        .result_valid(result_valid),
        .stall(stall),
        .busy(busy),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for a single IDLE cycle, then scrambles operands while counting busy cycles.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                 output int cycles);
        op_valid = 1'b1;
        op_code  = op;
        rs_val   = rs;
        rt_val   = rt;
        nextCycle();
        op_valid = 1'b0;
        cycles   = 0;
        while (busy && cycles < 200) begin
            rs_val = $urandom;
            rt_val = $urandom;
            nextCycle();
            cycles++;
        end
    endtask

    task automatic mfCheck(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        op_valid = 1'b1;
        op_code  = OP_MFHI;
        #1;
        checkOutput({name, " mfhi"}, result, exp_hi);
        checkOutput({name, " mfhi valid"}, {31'd0, result_valid}, 32'd1);
        op_code = OP_MFLO;
        #1;
        checkOutput({name, " mflo"}, result, exp_lo);
        op_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int stalls;
        int bad;

        vecs[0]  = '{OP_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
        vecs[1]  = '{OP_MTLO,  32'hCAFEF00D, 32'h0,        32'h12345678, 32'hCAFEF00D, 0};
        vecs[2]  = '{OP_MULT,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 4};
        vecs[3]  = '{OP_MULTU, 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, 4};
        vecs[4]  = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 4};
        vecs[5]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 4};
        vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[7]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 33};
`ifdef MULTDIV_DIV0_FAST_EN
        vecs[11] = '{OP_DIVU,  32'd7,        32'd0,        32'h0000000F, 32'h0FFFFFFF, 1};
        vecs[12] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'h0000000F, 32'h0FFFFFFF, 1};
`else
        vecs[11] = '{OP_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 33};
        vecs[12] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'h00000001, 33};
`endif
        vecs[13] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4};

        #2;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset stall", {31'd0, stall}, 32'd0);
        checkOutput("reset result_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        nextCycle();
        reset = 1'b0;
        nextCycle();

        // Reset ten cycles into a divide must abort it and clear HI/LO.
        op_valid = 1'b1;
        op_code  = OP_MTHI;
        rs_val   = 32'hDEADBEEF;
        nextCycle();
        op_code = OP_DIV;
        rs_val  = 32'hFFFFFFF9;
        rt_val  = 32'd2;
        nextCycle();
        op_valid = 1'b0;
        repeat (10) nextCycle();
        checkOutput("mid-div busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort hi", hi, 32'd0);
        checkOutput("abort lo", lo, 32'd0);
        #1;
        reset = 1'b0;
        mfCheck("after abort", 32'd0, 32'd0);
        nextCycle();

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, cyc);
            checkOutput($sformatf("vec%0d busy cycles", i), cyc, vecs[i].exp_cycles);
            checkOutput($sformatf("vec%0d hi", i), hi, vecs[i].exp_hi);
            checkOutput($sformatf("vec%0d lo", i), lo, vecs[i].exp_lo);
            mfCheck($sformatf("vec%0d", i), vecs[i].exp_hi, vecs[i].exp_lo);
            nextCycle();
        end

        // MFLO held through a divide: stalls every busy cycle, then reads the new quotient.
        op_valid = 1'b1;
        op_code  = OP_DIV;
        rs_val   = 32'hFFFFFF9C;
        rt_val   = 32'd7;
        nextCycle();
        op_code = OP_MFLO;
        rs_val  = 32'h55555555;
        #1;
        stalls = 0;
        bad    = 0;
        while (busy && stalls < 200) begin
            if (!stall || result_valid) bad++;
            stalls++;
            nextCycle();
        end
        checkOutput("held mflo stall cycles", stalls, 32'd33);
        checkOutput("held mflo bad stall cycles", bad, 32'd0);
        checkOutput("held mflo stall after", {31'd0, stall}, 32'd0);
        checkOutput("held mflo valid", {31'd0, result_valid}, 32'd1);
        checkOutput("held mflo result", result, 32'hFFFFFFF2);
        op_valid = 1'b0;
        checkOutput("held mflo hi", hi, 32'hFFFFFFFE);
        nextCycle();

        // MTHI held during a multiply is accepted on the first IDLE cycle and overrides HI.
        op_valid = 1'b1;
        op_code  = OP_MULT;
        rs_val   = 32'd3;
        rt_val   = 32'd5;
        nextCycle();
        op_code = OP_MTHI;
        rs_val  = 32'h0000ABCD;
        #1;
        stalls = 0;
        while (busy && stalls < 200) begin
            if (stall) stalls++;
            nextCycle();
            if (stalls > 100) break;
        end
        checkOutput("held mthi stall cycles", stalls, 32'd4);
        checkOutput("held mthi stall idle", {31'd0, stall}, 32'd0);
        nextCycle();
        op_valid = 1'b0;
        checkOutput("held mthi hi", hi, 32'h0000ABCD);
        checkOutput("held mthi lo", lo, 32'd15);
        checkOutput("held mthi busy", {31'd0, busy}, 32'd0);

        // MTHI followed directly by MFHI never raises busy.
        op_valid = 1'b1;
        op_code  = OP_MTHI;
        rs_val   = 32'h12345678;
        #1;
        checkOutput("mthi busy before", {31'd0, busy}, 32'd0);
        nextCycle();
        checkOutput("mthi busy after", {31'd0, busy}, 32'd0);
        op_code = OP_MFHI;
        #1;
        checkOutput("mthi-mfhi result", result, 32'h12345678);
        checkOutput("mthi-mfhi valid", {31'd0, result_valid}, 32'd1);
        op_valid = 1'b0;
        #1;
        checkOutput("idle result cleared", result, 32'd0);
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
